// File: rtl/hs_pkg.sv
// Shared definitions for the handshake skid slice: FSM state encoding and default widths.
package hs_pkg;

    localparam int HS_DATA_W_DEF = 32;
    localparam int HS_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/hs_xfer_counter.sv
// Free-running wrap counter of completed downstream transfers.
module hs_xfer_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Natural modulo-2^CNT_W arithmetic provides the wrap to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hs_skid_slice.sv
// Two-entry registered skid buffer (main + skid) on a valid/ready channel.
// Optional transfer counter and xfer_cnt port are enabled by defining HS_SKID_STATS_EN.
module hs_skid_slice
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W_DEF,
    parameter int CNT_W  = HS_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef HS_SKID_STATS_EN
    output logic [CNT_W-1:0]  xfer_cnt,
`endif
    output logic              data_success
);

    hs_state_e         state_q;
    hs_state_e         state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              s_ready_q;
    logic              m_valid_q;
    logic              success_q;

    logic              up_xfer;
    logic              dn_xfer;

    // s_ready is held low through reset, so acceptance must qualify on the flop.
    assign up_xfer = s_valid & s_ready_q;
    assign dn_xfer = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (up_xfer) begin
                    main_d  = s_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (up_xfer && m_ready) begin
                    main_d = s_data;
                end else if (up_xfer) begin
                    skid_d  = s_data;
                    state_d = ST_FULL;
                end else if (m_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (m_ready) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != ST_FULL);
            m_valid_q <= (state_d != ST_EMPTY);
            success_q <= dn_xfer;
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_data       = main_q;
    assign data_success = success_q;

`ifdef HS_SKID_STATS_EN
    hs_xfer_counter #(
        .CNT_W (CNT_W)
    ) u_xfer_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dn_xfer),
        .cnt   (xfer_cnt)
    );
`endif

endmodule

// File: tb/tb_hs_skid_slice.sv
// Scoreboard bench for hs_skid_slice: random/directed stimulus, FIFO reference model of at most two words.
module tb_hs_skid_slice;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          data_success;
`ifdef HS_SKID_STATS_EN
    logic [CW-1:0] xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    hs_skid_slice #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
`ifdef HS_SKID_STATS_EN
        .xfer_cnt     (xfer_cnt),
`endif
        .data_success (data_success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted words in order, occupancy bounded at two.
    logic [DW-1:0] sb_q[$];
    bit            ready_ok   = 1'b0;
    bit            exp_ds     = 1'b0;
    int            exp_cnt    = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            n_out      = 0;

    always @(negedge clk) begin
        bit exp_sr;
        bit exp_mv;
        bit up;
        bit dn;
        if (!rst_n) begin
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_m_data", 64'(m_data), 64'd0);
            chk("rst_success", 64'(data_success), 64'd0);
`ifdef HS_SKID_STATS_EN
            chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
            sb_q.delete();
            ready_ok   = 1'b0;
            exp_ds     = 1'b0;
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            exp_sr = ready_ok && (sb_q.size() < 2);
            exp_mv = (sb_q.size() > 0);
            chk("s_ready", 64'(s_ready), 64'(exp_sr));
            chk("m_valid", 64'(m_valid), 64'(exp_mv));
            if (exp_mv) begin
                chk("m_data", 64'(m_data), 64'(sb_q[0]));
            end
            if (prev_stall) begin
                chk("stall_hold", 64'(m_data), 64'(prev_data));
            end
            chk("data_success", 64'(data_success), 64'(exp_ds));
`ifdef HS_SKID_STATS_EN
            chk("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt % (1 << CW)));
`endif
            up         = s_valid && exp_sr;
            dn         = exp_mv && m_ready;
            prev_stall = exp_mv && !m_ready;
            prev_data  = m_data;
            exp_ds     = dn;
            if (dn) begin
                void'(sb_q.pop_front());
                exp_cnt++;
                n_out++;
            end
            if (up) begin
                sb_q.push_back(s_data);
            end
            ready_ok = 1'b1;
        end
    end

    // Called at posedge+1; holds s_valid until the word is accepted.
    task automatic push_word(input logic [DW-1:0] w);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 200;
        s_valid = 1'b1;
        s_data  = w;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=not_accepted required=accepted word=%0h", w);
        end
        $display("push word=%0h accepted=%0d t=%0t", w, acc, $time);
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single word
        m_ready = 1'b1;
        push_word(32'hA5A5_0001);
        idle(3);

        // Streaming 0..15
        for (int i = 0; i < 16; i++) begin
            push_word(DW'(i));
        end
        idle(3);

        // Backpressure: word 3 waits until the consumer frees a slot
        m_ready = 1'b0;
        push_word(32'd1);
        push_word(32'd2);
        fork
            push_word(32'd3);
            begin
                idle(4);
                m_ready = 1'b1;
            end
        join
        idle(4);

        // Random stalls on both sides
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc  = 0;
            while (sent < 1000 && cyc < 10000) begin
                m_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin
                    s_valid = 1'b1;
                    s_data  = 32'hC000_0000 + DW'(sent);
                end else begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                end
                @(negedge clk);
                if (s_valid && s_ready) sent++;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("random_sent", 64'(sent), 64'd1000);
            $display("random phase words=%0d cycles=%0d", sent, cyc);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle(4);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        // Reset while FULL: outputs clear immediately, nothing stale afterwards
        m_ready = 1'b0;
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_s_ready", 64'(s_ready), 64'd0);
        chk("async_m_valid", 64'(m_valid), 64'd0);
        chk("async_m_data", 64'(m_data), 64'd0);
        $display("reset asserted in FULL t=%0t", $time);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        idle(4);

        // 17 transfers after reset; a 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            push_word(32'hD000_0000 + DW'(i));
        end
        idle(3);
`ifdef HS_SKID_STATS_EN
        chk("wrap_cnt", 64'(xfer_cnt), 64'd1);
`endif
        chk("final_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hs_skid_slice.md
HS_SKID_SLICE -- requirements
Module: hs_skid_slice

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter CNT_W, default 16: transfer-counter width in bits, legal range 1..32.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_data, input, DATA_W bits: upstream payload.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream valid.
REQ-007 SHALL have port s_ready, output, 1 bit: upstream ready.
REQ-008 SHALL have port m_data, output, DATA_W bits: downstream payload.
REQ-009 SHALL have port m_valid, output, 1 bit: downstream valid.
REQ-010 SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-011 SHALL have port data_success, output, 1 bit: pulse per completed downstream transfer.
REQ-012 SHALL have port xfer_cnt, output, CNT_W bits: downstream transfer count; present only under HS_SKID_STATS_EN.

Function
REQ-013 SHALL define an upstream transfer as s_valid & s_ready, and a downstream transfer as m_valid & m_ready, each sampled at a rising clk edge.
REQ-014 SHALL implement a 2-entry skid buffer (main register plus skid register) with FSM states EMPTY, BUSY and FULL.
- EMPTY: no data held.
- BUSY: main register holds data.
- FULL: main and skid registers both hold data.
REQ-015 SHALL drive s_ready, m_valid and m_data directly from flops, with no combinational path from inputs to outputs.
REQ-016 SHALL set s_ready = (state != FULL) and m_valid = (state != EMPTY).
REQ-017 SHALL implement these state transitions:
- EMPTY, s_valid: main <= s_data, go to BUSY.
- BUSY, s_valid & m_ready: main <= s_data, stay in BUSY.
- BUSY, s_valid & !m_ready: skid <= s_data, go to FULL.
- BUSY, !s_valid & m_ready: go to EMPTY.
- FULL, m_ready: main <= skid, go to BUSY.
- All other cases: hold state and data.
REQ-018 SHALL give a latency of 1 cycle from an upstream transfer into EMPTY to m_valid high.
REQ-019 SHALL sustain one transfer per cycle when m_ready is held high.
REQ-020 SHALL hold m_data stable while m_valid & !m_ready.
REQ-021 SHALL never drop m_valid without a downstream transfer.
REQ-022 SHALL preserve payload order and neither duplicate nor lose a word.
REQ-023 SHALL drive data_success as a one-cycle pulse in the cycle after each downstream transfer, registered.
REQ-024 SHALL, when HS_SKID_STATS_EN is defined, increment xfer_cnt by 1 per downstream transfer and wrap from 2^CNT_W-1 to 0.
REQ-025 SHALL ignore s_data when s_valid is low.

Reset
REQ-026 SHALL, on rst_n low, immediately and asynchronously:
- set state = EMPTY, s_ready = 0, m_valid = 0, m_data = 0, data_success = 0, xfer_cnt = 0;
- discard all buffered data, including after assertion mid-transfer.
REQ-027 SHALL raise s_ready on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro HS_SKID_STATS_EN is defined, include the xfer_cnt port and counter.
REQ-029 SHALL, when HS_SKID_STATS_EN is undefined, omit the port and counter, with all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state typedef (EMPTY/BUSY/FULL, 2-bit encoding) and default width constants in shared package hs_pkg.
REQ-031 SHALL implement the wrap counter as sub-module hs_xfer_counter, parameterised by CNT_W, instantiated only under HS_SKID_STATS_EN.

Verification
REQ-032 SHALL cover the single-word case: after reset, with m_ready=1, drive s_data=32'hA5A5_0001 for one cycle -> m_valid=1 and m_data=32'hA5A5_0001 next cycle, data_success pulses one cycle later.
REQ-033 SHALL cover streaming: with m_ready=1, drive 16 back-to-back words 0..15 -> 16 outputs in order on consecutive cycles, s_ready held at 1.
REQ-034 SHALL cover backpressure: drive words 1,2,3 while m_ready=0 -> state FULL after word 2, s_ready=0, m_data stays 1; release m_ready -> outputs 1,2,3 in order.
REQ-035 SHALL cover random stalls: toggle s_valid and m_ready at 50% over 1000 words -> scoreboard matches exactly and m_data never changes while stalled.
REQ-036 SHALL cover reset mid-operation: pulse rst_n low in FULL -> m_valid=0, s_ready=0 and no stale word emitted after reset.
REQ-037 SHALL cover counter wrap: with HS_SKID_STATS_EN defined and CNT_W=4, perform 17 transfers -> xfer_cnt=1.
